// File: rtl/encode_dp_par.sv
// Byte-serialising front end of an LZF encoder: words in, bytes out, with pair-hash lookup and history capture.
// Latency: accepted word -> first byte on data 1 cycle later; lookup result 1 cycle after each byte accept.
// Backpressure: output register holds while data_ready is low; src_ready deasserts until the holding word drains.
module encode_dp_par #(
  parameter int IN_BYTES  = 8,
  parameter int LZF_WIDTH = 20,
  parameter int HASH_AW   = 8,
  parameter int HIST_AW   = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       src_valid,
  input  logic [8*IN_BYTES-1:0]      src_data,
  input  logic                       src_last,
  input  logic [$clog2(IN_BYTES):0]  src_nbytes,
  output logic                       src_ready,
  output logic [7:0]                 data,
  output logic                       data_valid,
  input  logic                       data_ready,
  output logic                       data_last,
  output logic                       hash_valid,
  output logic                       hash_hit,
  output logic [LZF_WIDTH-1:0]       hash_ref,
  output logic [LZF_WIDTH-1:0]       iidx,
  input  logic [HIST_AW-1:0]         hraddr,
  output logic [7:0]                 hdata,
  output logic                       init_done,
  output logic                       done,
  output logic [1:0]                 state_dbg
);
  localparam int NBW    = $clog2(IN_BYTES) + 1;
  localparam int HDEPTH = 1 << HASH_AW;
  localparam int EW     = 1 + 16 + LZF_WIDTH;   // {valid, byte pair, iidx}

  typedef enum logic [1:0] {ST_INIT = 2'd0, ST_IDLE = 2'd1, ST_PROC = 2'd2, ST_DONE = 2'd3} state_t;

  state_t                state_q, state_d;
  logic [HASH_AW-1:0]    waddr_q;
  logic                  init_done_q;
  logic [8*IN_BYTES-1:0] hold_dat_q;
  logic [NBW-1:0]        hold_cnt_q;
  logic                  hold_last_q;
  logic                  eos_q;
  logic [7:0]            data_q;
  logic                  data_valid_q;
  logic                  data_last_q;
  logic [LZF_WIDTH-1:0]  iidx_q;
  logic [7:0]            prev_q;
  logic                  acc_q;
  logic [15:0]           key_q;
  logic [HASH_AW-1:0]    h_q;
  logic [LZF_WIDTH-1:0]  aidx_q;
  logic [EW-1:0]         rd_q;
  logic [7:0]            hdata_q;
  logic [EW-1:0]         tab  [HDEPTH];
  logic [7:0]            hist [1 << HIST_AW];

  logic                  adv;
  logic                  take_byte;
  logic                  byte_acc;
  logic                  word_acc;
  logic [15:0]           key;
  logic [HASH_AW-1:0]    h;
  logic [NBW-1:0]        word_cnt;

  // Per-cycle transfer decisions and hash index of the byte being accepted
  always_comb begin
    adv       = !data_valid_q || data_ready;
    take_byte = adv && (hold_cnt_q != '0);
    byte_acc  = data_valid_q && data_ready;
    key       = {prev_q, data_q};
    h         = HASH_AW'(key ^ (key >> HASH_AW));
    word_cnt  = (src_last && (src_nbytes != '0)) ? src_nbytes : NBW'(IN_BYTES);
  end

  assign word_acc = src_valid && src_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  // Next-state logic: sweep table, wait for first word, run until final byte leaves
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (&waddr_q) state_d = ST_IDLE;
      ST_IDLE: if (word_acc) state_d = ST_PROC;
      ST_PROC: if (byte_acc && data_last_q) state_d = ST_DONE;
      default: state_d = state_q;
    endcase
  end

  // State-decoded outputs; a new word may land in the same cycle the last held byte moves out
  always_comb begin
    src_ready = 1'b0;
    if ((state_q == ST_IDLE || state_q == ST_PROC) && !eos_q)
      src_ready = (hold_cnt_q == '0) || ((hold_cnt_q == NBW'(1)) && adv);
    done      = (state_q == ST_DONE);
    state_dbg = state_q;
  end

  // Hash-table clear sweep and its completion flag
  always_ff @(posedge clk) begin
    if (rst) begin
      waddr_q     <= '0;
      init_done_q <= 1'b0;
    end else if (state_q == ST_INIT) begin
      waddr_q <= waddr_q + 1'b1;
      if (&waddr_q) init_done_q <= 1'b1;
    end
  end

  // Holding register: load on word accept, shift one byte out per transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_dat_q  <= '0;
      hold_cnt_q  <= '0;
      hold_last_q <= 1'b0;
      eos_q       <= 1'b0;
    end else if (word_acc) begin
      hold_dat_q  <= src_data;
      hold_cnt_q  <= word_cnt;
      hold_last_q <= src_last;
      eos_q       <= src_last;
    end else if (take_byte) begin
      hold_dat_q <= hold_dat_q >> 8;
      hold_cnt_q <= hold_cnt_q - 1'b1;
    end
  end

  // Output byte register: refills when empty or consumed, otherwise holds
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q       <= '0;
      data_valid_q <= 1'b0;
      data_last_q  <= 1'b0;
    end else if (adv) begin
      data_valid_q <= take_byte;
      data_last_q  <= take_byte && hold_last_q && (hold_cnt_q == NBW'(1));
      if (take_byte) data_q <= hold_dat_q[7:0];
    end
  end

  // Stream position and previous byte, advanced on every accepted byte
  always_ff @(posedge clk) begin
    if (rst) begin
      iidx_q <= '0;
      prev_q <= '0;
    end else if (byte_acc) begin
      iidx_q <= iidx_q + 1'b1;
      prev_q <= data_q;
    end
  end

  // Lookup stage: read the entry for this accept, forwarding the previous accept's not-yet-written entry
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= 1'b0;
      key_q  <= '0;
      h_q    <= '0;
      aidx_q <= '0;
      rd_q   <= '0;
    end else begin
      acc_q <= byte_acc;
      if (byte_acc) begin
        key_q  <= key;
        h_q    <= h;
        aidx_q <= iidx_q;
        if (acc_q && (h_q == h)) rd_q <= {1'b1, key_q, aidx_q};
        else                     rd_q <= tab[h];
      end
    end
  end

  // Table write port: clear sweep during INIT, otherwise commit the entry looked up last cycle
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) tab[waddr_q] <= '0;
    else if (acc_q)         tab[h_q]     <= {1'b1, key_q, aidx_q};
  end

  // History capture of every accepted byte at its stream position
  always_ff @(posedge clk) begin
    if (byte_acc && !rst) hist[iidx_q[HIST_AW-1:0]] <= data_q;
  end

  // Registered history read; a same-cycle write to the same address is not visible yet
  always_ff @(posedge clk) begin
    if (rst) hdata_q <= '0;
    else     hdata_q <= hist[hraddr];
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign data_last  = data_last_q;
  assign iidx       = iidx_q;
  assign init_done  = init_done_q;
  assign hdata      = hdata_q;
  assign hash_valid = acc_q;
  assign hash_hit   = acc_q && rd_q[EW-1] && (rd_q[EW-2 -: 16] == key_q);
  assign hash_ref   = rd_q[LZF_WIDTH-1:0];

endmodule

// File: tb/tb_encode_dp_par.sv
// Bench for encode_dp_par: table-driven last-word vectors, directed corner sequences, random stream vs. model.
// Model tracks expected bytes as a queue and the hash table / history as plain arrays indexed arithmetically.
// Inputs driven on the falling edge, outputs compared on the falling edge after the rising edge that produced them.
module tb_encode_dp_par;
  localparam int IB   = 8;
  localparam int LZW  = 12;
  localparam int HAW  = 8;
  localparam int HSW  = 11;
  localparam int HN   = 1 << HAW;
  localparam int IMOD = 1 << LZW;
  localparam int HMOD = 1 << HSW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            src_valid = 1'b0;
  logic [8*IB-1:0] src_data = '0;
  logic            src_last = 1'b0;
  logic [3:0]      src_nbytes = '0;
  logic            src_ready;
  logic [7:0]      data;
  logic            data_valid;
  logic            data_ready = 1'b0;
  logic            data_last;
  logic            hash_valid;
  logic            hash_hit;
  logic [LZW-1:0]  hash_ref;
  logic [LZW-1:0]  iidx;
  logic [HSW-1:0]  hraddr = '0;
  logic [7:0]      hdata;
  logic            init_done;
  logic            done;
  logic [1:0]      state_dbg;

  encode_dp_par #(.IN_BYTES(IB), .LZF_WIDTH(LZW), .HASH_AW(HAW), .HIST_AW(HSW)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
    .src_nbytes(src_nbytes), .src_ready(src_ready),
    .data(data), .data_valid(data_valid), .data_ready(data_ready), .data_last(data_last),
    .hash_valid(hash_valid), .hash_hit(hash_hit), .hash_ref(hash_ref), .iidx(iidx),
    .hraddr(hraddr), .hdata(hdata), .init_done(init_done), .done(done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] d; logic l; logic [3:0] nb; } word_t;
  typedef struct { logic [63:0] dat; logic [3:0] nb; int exp_n; logic [7:0] exp_lb; } vec_t;
  typedef struct packed { logic v; logic [15:0] pair; logic [LZW-1:0] idx; } tent_t;

  int nvec = 0;
  int nmis = 0;

  // stimulus
  word_t      wq[$];
  int         rdy_pct = 100;
  int         vld_pct = 100;
  // model
  logic [8:0] exp_q[$];
  tent_t      m_tab [HN];
  logic [7:0] m_hist [HMOD];
  logic       m_hknown [HMOD];
  int         m_iidx;
  logic [7:0] m_prev;
  logic       m_done;
  logic       pend_hash, exp_hit, pend_hd;
  logic [LZW-1:0] exp_ref;
  logic [7:0] exp_hd;
  int         pend_ord;
  int         n_acc;
  int         cyc = 0;
  logic [7:0] last_byte;
  logic       hit_log [64];
  logic [LZW-1:0] ref_log [64];
  int         acc_cyc [64];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    wq.delete();
    for (int i = 0; i < HN; i++) m_tab[i] = '0;
    for (int i = 0; i < HMOD; i++) m_hknown[i] = 1'b0;
    for (int i = 0; i < 64; i++) begin hit_log[i] = 1'bx; ref_log[i] = 'x; acc_cyc[i] = 0; end
    m_iidx = 0; m_prev = 8'h00; m_done = 1'b0;
    pend_hash = 1'b0; pend_hd = 1'b0; n_acc = 0; last_byte = 8'h00;
  endtask

  // One clock: check what the last edge produced, drive this cycle, then model the coming edge.
  task automatic step();
    logic [8:0]  e;
    logic [63:0] d;
    int          n, ki, hi;
    @(negedge clk);
    cyc++;
    chk("hash_valid", hash_valid, pend_hash);
    if (pend_hash) begin
      chk("hash_hit", hash_hit, exp_hit);
      chk("hash_ref", hash_ref, exp_ref);
      if (pend_ord < 64) begin hit_log[pend_ord] = hash_hit; ref_log[pend_ord] = hash_ref; end
    end
    if (pend_hd) chk("hdata", hdata, exp_hd);
    chk("iidx", iidx, m_iidx);
    chk("done", done, m_done);

    data_ready = ($urandom_range(0, 99) < rdy_pct);
    if (wq.size() > 0 && $urandom_range(0, 99) < vld_pct) begin
      src_valid = 1'b1; src_data = wq[0].d; src_last = wq[0].l; src_nbytes = wq[0].nb;
    end else begin
      src_valid = 1'b0;
    end
    hraddr = HSW'($urandom_range(0, HMOD - 1));
    #1;
    if (m_done) chk("src_ready_done", src_ready, 0);

    pend_hd   = m_hknown[hraddr];
    exp_hd    = m_hist[hraddr];
    pend_hash = 1'b0;
    if (data_valid && data_ready) begin
      if (n_acc < 64) acc_cyc[n_acc] = cyc;
      if (exp_q.size() == 0) begin
        chk("spurious_byte", data_valid, 0);
      end else begin
        e = exp_q.pop_front();
        chk("data", data, e[7:0]);
        chk("data_last", data_last, e[8]);
        ki = {m_prev, e[7:0]};
        hi = (ki ^ (ki >> HAW)) % HN;
        exp_hit   = m_tab[hi].v && (m_tab[hi].pair == 16'(ki));
        exp_ref   = m_tab[hi].idx;
        pend_hash = 1'b1;
        pend_ord  = n_acc;
        m_tab[hi] = '{v: 1'b1, pair: 16'(ki), idx: LZW'(m_iidx)};
        m_hist[m_iidx % HMOD]   = e[7:0];
        m_hknown[m_iidx % HMOD] = 1'b1;
        m_prev    = e[7:0];
        last_byte = data;
        if (e[8]) m_done = 1'b1;
        m_iidx = (m_iidx + 1) % IMOD;
      end
      n_acc++;
    end
    if (src_valid && src_ready) begin
      d = wq[0].d;
      n = wq[0].l ? ((wq[0].nb == 0) ? IB : int'(wq[0].nb)) : IB;
      for (int i = 0; i < n; i++) exp_q.push_back({(wq[0].l && i == n - 1), d[8*i +: 8]});
      void'(wq.pop_front());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; src_valid = 1'b0; data_ready = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {src_ready, data, data_valid, data_last, hash_valid, hash_hit, hash_ref,
                          iidx, hdata, init_done, done, state_dbg}, 0);
    model_reset();
    rst = 1'b0;
  endtask

  task automatic wait_init();
    int   k   = 0;
    logic bad = 1'b0;
    while (!init_done && k < 1000) begin
      step();
      k++;
      if (src_ready && !init_done) bad = 1'b1;
    end
    chk("init_cycles", k, HN);
    chk("src_ready_in_init", bad, 0);
  endtask

  task automatic run_until_done(input int bound);
    int k = 0;
    while (!m_done && k < bound) begin step(); k++; end
    chk("timeout_done", m_done, 1);
    step();
  endtask

  vec_t  vt [10];
  int    total;
  word_t w;

  initial begin
    vt[0] = '{64'h8877665544332211, 4'd0, 8, 8'h88};
    vt[1] = '{64'h8877665544332211, 4'd1, 1, 8'h11};
    vt[2] = '{64'h8877665544332211, 4'd2, 2, 8'h22};
    vt[3] = '{64'h8877665544332211, 4'd3, 3, 8'h33};
    vt[4] = '{64'h8877665544332211, 4'd4, 4, 8'h44};
    vt[5] = '{64'h8877665544332211, 4'd5, 5, 8'h55};
    vt[6] = '{64'h8877665544332211, 4'd6, 6, 8'h66};
    vt[7] = '{64'h8877665544332211, 4'd7, 7, 8'h77};
    vt[8] = '{64'h8877665544332211, 4'd8, 8, 8'h88};
    vt[9] = '{64'h1234567899CCBBAA, 4'd3, 3, 8'hCC};
    model_reset();

    // Last-word byte counts, including nbytes=0 meaning a full word
    for (int v = 0; v < 10; v++) begin
      do_reset();
      wait_init();
      wq.push_back('{vt[v].dat, 1'b1, vt[v].nb});
      rdy_pct = 100; vld_pct = 100;
      run_until_done(60);
      chk("nb_count", n_acc, vt[v].exp_n);
      chk("nb_last_byte", last_byte, vt[v].exp_lb);
      chk("nb_done", done, 1);
      chk("nb_src_ready_after", src_ready, 0);
    end

    // Two back-to-back words: 16 bytes on 16 consecutive cycles
    do_reset();
    wait_init();
    wq.push_back('{64'h0706050403020100, 1'b0, 4'd0});
    wq.push_back('{64'h0F0E0D0C0B0A0908, 1'b1, 4'd0});
    run_until_done(60);
    chk("b2b_count", n_acc, 16);
    chk("b2b_span", acc_cyc[15] - acc_cyc[0], 15);
    chk("b2b_iidx", iidx, 16);

    // Five-cycle stall mid-word: byte 2 must sit on the output untouched
    do_reset();
    wait_init();
    wq.push_back('{64'h0706050403020100, 1'b0, 4'd0});
    wq.push_back('{64'h0F0E0D0C0B0A0908, 1'b1, 4'd0});
    repeat (4) step();
    rdy_pct = 0;
    repeat (5) begin
      step();
      chk("stall_data", data, 8'h02);
      chk("stall_valid", data_valid, 1);
      chk("stall_iidx", iidx, 2);
    end
    rdy_pct = 100;
    run_until_done(60);
    chk("stall_total", n_acc, 16);

    // "ABAB": pairs AB and BA share hash bucket 0x03 at HASH_AW=8, so the 4th byte
    // finds the BA entry written by byte 3 (ref 2) and reports no hit.
    do_reset();
    wait_init();
    wq.push_back('{64'h0000000042414241, 1'b1, 4'd4});
    run_until_done(60);
    chk("abab_hit_b2", hit_log[1], 0);
    chk("abab_hit_b4", hit_log[3], 0);
    chk("abab_ref_b4", ref_log[3], 2);

    // "ABCAB": AB repeats with no intervening collision -> hit on byte 5, ref 1
    do_reset();
    wait_init();
    wq.push_back('{64'h0000004241434241, 1'b1, 4'd5});
    run_until_done(60);
    chk("abcab_hit_b2", hit_log[1], 0);
    chk("abcab_hit_b5", hit_log[4], 1);
    chk("abcab_ref_b5", ref_log[4], 1);

    // Reset after 10 bytes of "ABCABC..": table must forget the AB pair
    do_reset();
    wait_init();
    repeat (3) wq.push_back('{64'h4241434241434241, 1'b0, 4'd0});
    begin
      int k = 0;
      while (n_acc < 10 && k < 100) begin step(); k++; end
      chk("pre_reset_bytes", n_acc, 10);
      chk("pre_reset_hit_b5", hit_log[4], 1);
    end
    do_reset();
    wait_init();
    wq.push_back('{64'h0000000000004241, 1'b1, 4'd2});
    run_until_done(60);
    chk("post_reset_hit_b1", hit_log[0], 0);
    chk("post_reset_hit_b2", hit_log[1], 0);

    // Random long stream over a 4-letter alphabet, past the iidx wrap
    do_reset();
    wait_init();
    total = 0;
    for (int wi = 0; wi < 540; wi++) begin
      for (int b = 0; b < IB; b++) w.d[8*b +: 8] = 8'h41 + 8'($urandom_range(0, 3));
      w.l  = (wi == 539);
      w.nb = w.l ? 4'($urandom_range(0, IB)) : 4'd0;
      wq.push_back(w);
      total += w.l ? ((w.nb == 0) ? IB : int'(w.nb)) : IB;
    end
    rdy_pct = 70; vld_pct = 80;
    run_until_done(40000);
    chk("rand_count", n_acc, total);
    chk("rand_wrap_iidx", iidx, total % IMOD);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
